// File: rtl/row_five_checker_if.sv
// Request/result bundle for the row five-in-a-row checker.
// The master side supplies a packed row and the stone code to search for.
// The slave side returns busy/done and the location of the winning run.
interface row_five_checker_if #(
    parameter int POINTS = 16
);
    localparam int IDX_W = $clog2(POINTS);

    logic                  start;
    logic [2*POINTS-1:0]   row;
    logic [1:0]            player;
    logic                  busy;
    logic                  done;
    logic                  win;
    logic [IDX_W-1:0]      win_start;
    logic [IDX_W-1:0]      win_end;

    modport master (
        output start, row, player,
        input  busy, done, win, win_start, win_end
    );

    modport slave (
        input  start, row, player,
        output busy, done, win, win_start, win_end
    );
endinterface

// File: rtl/row_five_checker.sv
// Sequential five-in-a-row detector for one board row.
// One point is examined per SCAN cycle. The first run of RUN matching stones
// ends the scan early, so the lowest-indexed run is the one reported.
// Every output comes straight from a register.
module row_five_checker #(
    parameter int POINTS = 16,
    parameter int RUN    = 5
) (
    input  logic              clock,
    input  logic              reset,
    row_five_checker_if.slave bus
);
    localparam int IDX_W = $clog2(POINTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(POINTS - 1);
    localparam logic [IDX_W-1:0] RUN_SPAN = IDX_W'(RUN - 1);
    localparam logic [2:0]       RUN_CNT  = 3'(RUN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_reg;
    logic [2*POINTS-1:0] row_reg;
    logic [1:0]          player_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic [2:0]          cnt_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                win_reg;
    logic [IDX_W-1:0]    win_start_reg;
    logic [IDX_W-1:0]    win_end_reg;

    // Unpack the latched row into per-point codes for indexed selection.
    logic [1:0] points [POINTS];
    genvar gi;
    generate
        for (gi = 0; gi < POINTS; gi++) begin : g_points
            assign points[gi] = row_reg[2*gi +: 2];
        end
    endgenerate

    // Empty (00) and invalid (11) codes never match, so a bad player code
    // simply runs the full scan without finding anything.
    logic player_valid;
    logic point_match;
    logic hit_run;
    assign player_valid = (player_reg == 2'b01) || (player_reg == 2'b10);
    assign point_match  = player_valid && (points[idx_reg] == player_reg);
    assign hit_run      = point_match && ((cnt_reg + 3'd1) == RUN_CNT);

    // Control FSM; also owns all result registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            row_reg       <= '0;
            player_reg    <= '0;
            idx_reg       <= '0;
            cnt_reg       <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            win_reg       <= 1'b0;
            win_start_reg <= '0;
            win_end_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        row_reg       <= bus.row;
                        player_reg    <= bus.player;
                        win_reg       <= 1'b0;
                        win_start_reg <= '0;
                        win_end_reg   <= '0;
                        idx_reg       <= '0;
                        cnt_reg       <= '0;
                        busy_reg      <= 1'b1;
                        state_reg     <= SCAN;
                    end
                end
                SCAN: begin
                    cnt_reg <= point_match ? (cnt_reg + 3'd1) : 3'd0;
                    if (hit_run) begin
                        win_reg       <= 1'b1;
                        win_end_reg   <= idx_reg;
                        win_start_reg <= idx_reg - RUN_SPAN;
                        done_reg      <= 1'b1;
                        state_reg     <= DONE;
                    end else if (idx_reg == LAST_IDX) begin
                        done_reg      <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        idx_reg       <= idx_reg + 1'b1;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.win       = win_reg;
    assign bus.win_start = win_start_reg;
    assign bus.win_end   = win_end_reg;
endmodule

// File: doc/row_five_checker.md
ROW_FIVE_CHECKER -- requirements
Module: row_five_checker

Interface
REQ-001 The block SHALL have parameter POINTS, default 16, the number of 2-bit points per row.
REQ-002 The block SHALL have parameter RUN, default 5, the consecutive-stone count that constitutes a win.
REQ-003 The block SHALL have port clock  input  1  single system clock, all state changes on the rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  request to check one row, sampled only in IDLE.
REQ-006 The block SHALL have port row  input  2*POINTS  16 packed point codes, point i at bits [2i+1:2i], the same layout as the board row store output.
REQ-007 The block SHALL have port player  input  2  stone code to search for.
REQ-008 The block SHALL have port busy  output  1  high while a check is in progress (state != IDLE).
REQ-009 The block SHALL have port done  output  1  one-cycle pulse when the result is valid.
REQ-010 The block SHALL have port win  output  1  run of RUN found; held until the next accepted start or reset.
REQ-011 The block SHALL have port win_start  output  4  lowest point index of the winning run.
REQ-012 The block SHALL have port win_end  output  4  highest point index of the winning run.

Function
REQ-013 Point codes SHALL be 00 = empty, 01 = player 1, 10 = player 2, 11 = invalid; a point matches only if its code equals player and player is 01 or 10.
REQ-014 The FSM SHALL have states IDLE, SCAN and DONE.
REQ-015 IDLE with start=1 SHALL latch row and player, clear win/win_start/win_end, set idx=0 and cnt=0, and go to SCAN.
REQ-016 IDLE with start=0 SHALL hold all state and outputs.
REQ-017 Each SCAN cycle SHALL evaluate latched point idx: on a match cnt becomes cnt+1, otherwise cnt becomes 0.
REQ-018 When cnt+1 equals RUN on a match, the block SHALL set win=1, win_end=idx and win_start=idx-(RUN-1), and go to DONE (early exit; the lowest-indexed run wins).
REQ-019 Otherwise, when idx equals POINTS-1, the block SHALL keep win=0 and go to DONE; otherwise idx SHALL increment.
REQ-020 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-021 Latency: if the scan ends at point k, done SHALL be high in the cycle after the (k+1)-th rising edge following the edge that sampled start; a no-win scan takes 16 edges.
REQ-022 start in SCAN or DONE SHALL be ignored, and row/player changes during a scan SHALL have no effect.
REQ-023 A run longer than RUN SHALL report its first RUN points only.
REQ-024 An invalid player code (00 or 11) SHALL complete a full scan with win=0.
REQ-025 cnt SHALL be 3 bits wide and saturate by construction, since the FSM exits when cnt reaches RUN.
REQ-026 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-027 reset=1 SHALL asynchronously force state=IDLE, idx=0, cnt=0, latched row/player=0, busy=0, done=0, win=0, win_start=0 and win_end=0.
REQ-028 Reset mid-SCAN or in DONE SHALL abort the check with no done pulse.
REQ-029 The first start SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-030 The bench SHALL drive row=all 00, player=01, start pulse -> busy high; done on edge 16 after start; win=0, win_start=0, win_end=0.
REQ-031 The bench SHALL drive player=01 with points 3..7=01 and all others 00 -> done on edge 8; win=1, win_start=3, win_end=7.
REQ-032 The bench SHALL drive player=10 with points 11..15=10 and point 10=01 -> done on edge 16; win=1, win_start=11, win_end=15.
REQ-033 The bench SHALL drive player=01 with points 0..3=01, point 4=10 and points 5..8=01 -> done on edge 16; win=0.
REQ-034 The bench SHALL drive player=01 with points 2..7=01 -> done on edge 7; win_start=2, win_end=6; a start pulsed at edge 3 is ignored.
REQ-035 The bench SHALL assert reset at edge 4 of a scan -> busy/done/win drop to 0 immediately; no done pulse; a new start after reset is accepted and completes normally.
